pipe_stage_buffer: RTL and testbench

- Parametrised elastic pipeline-stage register. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffers into one block.
- Stall/nop controls are replaced by a valid/ready handshake, DEPTH-entry skid storage, a flush with NOP substitution, and occupancy/drop statistics.
- It sits between any two CPU pipeline stages. Payload is an opaque WIDTH-bit vector, normally a packed {ctrl word, monitor word, datapath words} struct.

---
 rtl/pipe_pkg.sv | 77 +++++++
 rtl/pipe_buffer_mem.sv | 27 ++
 rtl/pipe_stage_buffer.sv | 102 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline-stage buffers.
// Payload structs let each stage boundary instantiate with WIDTH = $bits(<struct>).
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [6:0] {
        op_load   = 7'b0000011,
        op_imm    = 7'b0010011,
        op_auipc  = 7'b0010111,
        op_store  = 7'b0100011,
        op_reg    = 7'b0110011,
        op_lui    = 7'b0110111,
        op_branch = 7'b1100011,
        op_jalr   = 7'b1100111,
        op_jal    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic [3:0]  alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        opcode_e     opcode;
    } mon_t;

    // Monitor word carried by a bubble: a canonical addi x0,x0,0.
    localparam mon_t MON_NOP = '{pc: 32'h0, inst: NOP_INST, opcode: op_imm};

    typedef struct packed {
        mon_t        mon;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        ctrl_t       ctrl;
        mon_t        mon;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        ctrl_t       ctrl;
        mon_t        mon;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t       ctrl;
        mon_t        mon;
        logic [31:0] wb_data;
        logic [4:0]  rd;
    } mem_wb_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buffer_mem.sv
// DEPTH x WIDTH storage for pipe_stage_buffer: one write port, one async read port.
module pipe_buffer_mem
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [ptr_width(DEPTH)-1:0]    wr_ptr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic [ptr_width(DEPTH)-1:0]    rd_ptr,
    output logic [WIDTH-1:0]               rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Data storage only; validity is tracked by the owner, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: valid/ready handshake, DEPTH-entry FIFO storage,
// flush with NOP substitution on the output and a saturating count of flushed beats.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 2,
    parameter bit               PIPE_READY = 1'b0,
    parameter logic [WIDTH-1:0] NOP_VALUE  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned   CW       = cnt_width(DEPTH);
    localparam int unsigned   PW       = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] wr_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [15:0]   drop_cnt_nxt;
    logic [16:0]   drop_sum;
    logic [WIDTH-1:0] head;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    // With PIPE_READY clear a full buffer still accepts when the head leaves this cycle.
    assign in_ready  = PIPE_READY ? !full : (!full || out_ready);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = out_valid ? head : NOP_VALUE;

    pipe_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (in_data),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    // Next-state: flush overrides push/pop and charges every discarded valid beat.
    always_comb begin
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        drop_cnt_nxt = drop_cnt;
        drop_sum     = 17'(drop_cnt) + 17'(count) + 17'(in_valid);
        if (flush) begin
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            drop_cnt_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else begin
            if (push) begin
                wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_nxt = count + CW'(1);
            end else if (pop && !push) begin
                count_nxt = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: three configurations share one stimulus stream,
// each tracked by a queue-based model of the buffer contents and flush statistics.
module tb_pipe_stage_buffer;

    localparam int unsigned    W    = 8;
    localparam logic [W-1:0]   NOP  = 8'hE5;
    localparam int             NDUT = 3;
    localparam int             DEP [NDUT] = '{2, 2, 3};
    localparam bit             PR  [NDUT] = '{1'b0, 1'b1, 1'b0};

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [W-1:0] out_data_w  [NDUT];
    logic [1:0]   count_w     [NDUT];
    logic [15:0]  drop_w      [NDUT];

    logic [W-1:0] exp_q  [NDUT][$];
    int           drop_m [NDUT];
    bit           rdy_m  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(2), .PIPE_READY(1'b0), .NOP_VALUE(NOP)) u_d2_p0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(out_data_w[0]), .count(count_w[0]), .drop_cnt(drop_w[0]));

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(2), .PIPE_READY(1'b1), .NOP_VALUE(NOP)) u_d2_p1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(out_data_w[1]), .count(count_w[1]), .drop_cnt(drop_w[1]));

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(3), .PIPE_READY(1'b0), .NOP_VALUE(NOP)) u_d3_p0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_data(in_data), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .out_data(out_data_w[2]), .count(count_w[2]), .drop_cnt(drop_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check state at +1, update model at +3 (after monitor pop).
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        int sum;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            rdy_m[k] = (exp_q[k].size() < DEP[k]) || (!PR[k] && ordy);
            check("in_ready", k, 32'(in_ready_w[k]), 32'(rdy_m[k]));
            check("count", k, 32'(count_w[k]), 32'(exp_q[k].size()));
            check("drop_cnt", k, 32'(drop_w[k]), 32'(drop_m[k]));
        end
        #2;
        for (int k = 0; k < NDUT; k++) begin
            if (fl) begin
                sum = drop_m[k] + exp_q[k].size() + (iv ? 1 : 0);
                drop_m[k] = (sum > 65535) ? 65535 : sum;
                exp_q[k].delete();
            end else if (iv && rdy_m[k]) begin
                exp_q[k].push_back(d);
            end
        end
    endtask

    // Monitor: compares the presented head against the model and retires consumed beats.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < NDUT; k++) begin
                check("out_valid", k, 32'(out_valid_w[k]), 32'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    check("out_data", k, 32'(out_data_w[k]), 32'(exp_q[k][0]));
                    if (out_ready && !flush && rst) void'(exp_q[k].pop_front());
                end else begin
                    check("out_nop", k, 32'(out_data_w[k]), 32'(NOP));
                end
            end
        end
    end

    task automatic async_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++)
            check("count_pre_rst", k, 32'(count_w[k]), 32'(exp_q[k].size()));
        #2;
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            drop_m[k] = 0;
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_count", k, 32'(count_w[k]), 32'd0);
            check("rst_out_valid", k, 32'(out_valid_w[k]), 32'd0);
            check("rst_in_ready", k, 32'(in_ready_w[k]), 32'd1);
            check("rst_drop", k, 32'(drop_w[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset / empty
        repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure then push into a full buffer while the head leaves
        cycle(1'b1, 8'h0A, 1'b0, 1'b0);
        cycle(1'b1, 8'h0B, 1'b0, 1'b0);
        cycle(1'b1, 8'h0C, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with two stored entries plus a live input beat, then flush while empty
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Ordered sequence with throttled downstream
        for (int i = 1; i <= 10; i++)
            cycle(1'b1, W'(i), 1'($urandom_range(0, 1)), 1'b0);
        repeat (6) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
        repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 39) == 0));

        // Asynchronous reset with entries in flight
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0);
        async_reset();
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
